// File: rtl/alu_vec.sv
// Lane-wise vector ALU: element lanes of element bits each, second operand taken
// from vectorB or a broadcast scalar, with a combinational result and a registered copy.
module alu_vec #(
  parameter int unsigned element = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [element-1:0][element-1:0]   vectorA,
  input  logic [element-1:0][element-1:0]   vectorB,
  input  logic [15:0]                       scalar,
  input  logic [2:0]                        sel,
  input  logic                              operand_flag,
  output logic [element-1:0][element-1:0]   result,
  output logic [element-1:0][element-1:0]   result_q
);

  for (genvar lane = 0; lane < element; lane++) begin : g_lane
    logic [element-1:0] a;
    logic [element-1:0] b;
    logic [3:0]         shamt;
    logic               shift_over;
    logic [element-1:0] lane_res;

    assign a          = vectorA[lane];
    assign b          = operand_flag ? scalar[element-1:0] : vectorB[lane];
    assign shamt      = b[3:0];
    // Only reachable for element < 16, where a 4-bit amount can exceed the lane.
    assign shift_over = {28'd0, shamt} >= element;

    always_comb begin
      lane_res = '0;
      unique case (sel)
        3'b000: lane_res = a + b;
        3'b001: lane_res = a - b;
        3'b010: lane_res = a * b;
        3'b011: lane_res = a & b;
        3'b100: lane_res = a | b;
        3'b101: lane_res = a ^ b;
        3'b110: lane_res = shift_over ? '0 : a << shamt;
        3'b111: lane_res = shift_over ? '0 : a >> shamt;
      endcase
    end

    assign result[lane] = lane_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result;
    end
  end

endmodule

// File: tb/tb_alu_vec.sv
// Directed-vector bench for alu_vec (element = 16) using immediate assertions.
module tb_alu_vec;

  logic               clk;
  logic               rst;
  logic [15:0][15:0]  vectorA;
  logic [15:0][15:0]  vectorB;
  logic [15:0]        scalar;
  logic [2:0]         sel;
  logic               operand_flag;
  logic [15:0][15:0]  result;
  logic [15:0][15:0]  result_q;

  int checks = 0;
  int errors = 0;

  logic [255:0] exp_add;

  alu_vec #(.element(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .vectorA      (vectorA),
    .vectorB      (vectorB),
    .scalar       (scalar),
    .sel          (sel),
    .operand_flag (operand_flag),
    .result       (result),
    .result_q     (result_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] bcast(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b0;
    vectorA      = '0;
    vectorB      = '0;
    scalar       = '0;
    sel          = 3'b000;
    operand_flag = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset_rq", result_q, '0);

    // Add, vector operand
    vectorA = {16'hABCD, 16'hBA98, 16'h7654, 16'h3210, 192'h0};
    vectorB = {16'h1122, 16'h3344, 16'h5566, 16'h7788,
               16'h9900, 16'hAABB, 16'hCCDD, 16'hEEFF, 128'h0};
    exp_add = {16'hBCEF, 16'hEDDC, 16'hCBBA, 16'hA998,
               16'h9900, 16'hAABB, 16'hCCDD, 16'hEEFF, 128'h0};
    #1 chk("add_vec", result, exp_add);
    chk("rq_held_in_rst", result_q, '0);

    // Add wrap, no carry into lane 1
    vectorA = {224'h0, 16'h1234, 16'hFFFF};
    vectorB = {224'h0, 16'h0000, 16'h0001};
    #1 chk("add_wrap", result, {224'h0, 16'h1234, 16'h0000});

    // Subtract borrow stays in lane 0
    sel     = 3'b001;
    vectorA = {224'h0, 16'h0005, 16'h0000};
    vectorB = {224'h0, 16'h0000, 16'h0001};
    #1 chk("sub_no_borrow_x", result, {bcast(16'h0000) | {224'h0, 16'h0005, 16'hFFFF}});

    // Scalar broadcast subtract
    vectorA      = bcast(16'h0064);
    vectorB      = bcast(16'h1111);
    scalar       = 16'h0065;
    operand_flag = 1'b1;
    #1 chk("sub_scalar", result, bcast(16'hFFFF));

    // Logic ops
    operand_flag = 1'b0;
    vectorA      = bcast(16'hF0F0);
    vectorB      = bcast(16'h0FF0);
    sel = 3'b011; #1 chk("and", result, bcast(16'h00F0));
    sel = 3'b100; #1 chk("or",  result, bcast(16'hFFF0));
    sel = 3'b101; #1 chk("xor", result, bcast(16'hFF00));

    // Multiply
    sel     = 3'b010;
    vectorA = bcast(16'h0100);
    vectorB = bcast(16'h0100);
    #1 chk("mul_ovf", result, bcast(16'h0000));
    vectorA = {224'h0, 16'h1234, 16'h0003};
    vectorB = {224'h0, 16'h0010, 16'h0005};
    #1 chk("mul_small", result, {224'h0, 16'h2340, 16'h000F});

    // Shifts by scalar 1
    vectorA      = bcast(16'h8001);
    scalar       = 16'h0001;
    operand_flag = 1'b1;
    sel = 3'b110; #1 chk("shl1", result, bcast(16'h0002));
    sel = 3'b111; #1 chk("shr1", result, bcast(16'h4000));

    // Shift amount uses only b[3:0]
    scalar = 16'h001F;
    sel = 3'b110; #1 chk("shl15", result, bcast(16'h8000));
    sel = 3'b111; #1 chk("shr15", result, bcast(16'h0001));
    operand_flag = 1'b0;
    vectorB      = bcast(16'h0012);
    #1 chk("shr_vec2", result, bcast(16'h2000));

    // Registered copy
    sel     = 3'b000;
    vectorA = {16'hABCD, 16'hBA98, 16'h7654, 16'h3210, 192'h0};
    vectorB = {16'h1122, 16'h3344, 16'h5566, 16'h7788,
               16'h9900, 16'hAABB, 16'hCCDD, 16'hEEFF, 128'h0};
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rq_load", result_q, exp_add);
    #2 rst = 1'b1;
    #1 chk("rq_async_rst", result_q, '0);
    chk("res_in_rst", result, exp_add);
    @(posedge clk); #1;
    chk("rq_rst_hold", result_q, '0);
    rst = 1'b0;
    #1 chk("rq_before_edge", result_q, '0);
    chk("res_after_rst", result, exp_add);
    @(posedge clk); #1;
    chk("rq_first_edge", result_q, exp_add);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
